// File: rtl/bcd_down_counter.sv
// Cascadable DIGITS-digit BCD down counter with parallel load, optional
// wrap-around (all-zero -> all-nine) and one-cycle borrow/done/load_err pulses.
module bcd_down_counter #(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  borrow_out,
    output logic                  done,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] load_val;
    logic         load_bad;
    logic [W-1:0] dec_val;
    logic         dec_br;
    logic [3:0]   dig;
    logic [W-1:0] q_next;
    logic         borrow_next;
    logic         done_next;
    logic         err_next;

    assign zero = (q == '0);

    // Load sanitising: out-of-range digits are stored as 9 and flagged.
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd9;
                load_bad           = 1'b1;
            end else begin
                load_val[4*i +: 4] = d[4*i +: 4];
            end
        end
    end

    // Ripple-borrow decrement; all-zero naturally rolls over to all-nine.
    always_comb begin
        dec_val = '0;
        dec_br  = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = q[4*i +: 4];
            if (dig > 4'd9) begin
                dig = 4'd9;
            end
            if (dec_br) begin
                if (dig == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = dig - 4'd1;
                    dec_br            = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = dig;
            end
        end
    end

    // Next-state selection: load > count > hold.
    always_comb begin
        q_next      = q;
        borrow_next = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        if (load) begin
            q_next   = load_val;
            err_next = load_bad;
        end else if (en) begin
            if (zero) begin
                if (WRAP) begin
                    q_next      = dec_val;
                    borrow_next = 1'b1;
                end
            end else begin
                q_next    = dec_val;
                done_next = (dec_val == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q          <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            q          <= q_next;
            borrow_out <= borrow_next;
            done       <= done_next;
            load_err   <= err_next;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: wrapping and stop-at-zero instances driven in parallel
// and compared against an integer-valued reference model.
module tb_bcd_down_counter;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         clear;
    logic         en;
    logic         load;
    logic [W-1:0] d;

    logic [W-1:0] q_w, q_s;
    logic         zero_w, zero_s, borrow_w, borrow_s, done_w, done_s, err_w, err_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, index 0 = stop-at-zero, index 1 = wrapping.
    int m_val[2];
    int m_borrow[2];
    int m_done[2];
    int m_err[2];

    bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .clear(clear), .en(en), .load(load), .d(d),
        .q(q_w), .zero(zero_w), .borrow_out(borrow_w), .done(done_w), .load_err(err_w)
    );

    bcd_down_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_stop (
        .clk(clk), .clear(clear), .en(en), .load(load), .d(d),
        .q(q_s), .zero(zero_s), .borrow_out(borrow_s), .done(done_s), .load_err(err_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_borrow[k] = 0; m_done[k] = 0; m_err[k] = 0;
        end
    endtask

    // One rising edge of the specified behaviour, using plain decimal arithmetic.
    task automatic model_edge();
        int dv, v, bad;
        for (int k = 0; k < 2; k++) begin
            m_borrow[k] = 0; m_done[k] = 0; m_err[k] = 0;
            if (load) begin
                v = 0; bad = 0;
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    dv = int'((d >> (4 * i)) & 8'hF);
                    if (dv > 9) begin dv = 9; bad = 1; end
                    v = v * 10 + dv;
                end
                m_val[k] = v;
                m_err[k] = bad;
            end else if (en) begin
                if (m_val[k] == 0) begin
                    if (k == 1) begin
                        m_val[k]    = 99;
                        m_borrow[k] = 1;
                    end
                end else begin
                    m_val[k]--;
                    m_done[k] = (m_val[k] == 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("wrap q",      int'(q_w),      to_bcd(m_val[1]));
        check("wrap zero",   int'(zero_w),   (m_val[1] == 0) ? 1 : 0);
        check("wrap borrow", int'(borrow_w), m_borrow[1]);
        check("wrap done",   int'(done_w),   m_done[1]);
        check("wrap err",    int'(err_w),    m_err[1]);
        check("stop q",      int'(q_s),      to_bcd(m_val[0]));
        check("stop zero",   int'(zero_s),   (m_val[0] == 0) ? 1 : 0);
        check("stop borrow", int'(borrow_s), m_borrow[0]);
        check("stop done",   int'(done_s),   m_done[0]);
        check("stop err",    int'(err_s),    m_err[0]);
    endtask

    task automatic cycle(input logic l, input logic e, input logic [W-1:0] dv);
        load = l; en = e; d = dv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Clear asserted between edges must act without a clock edge.
    task automatic async_reset();
        #3;
        clear = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; en = 1'b0; load = 1'b0; d = '0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        clear = 1'b1;

        // Count from reset through the wrap.
        repeat (3) cycle(1'b0, 1'b1, 8'h00);
        check("plan wrap 97", int'(q_w), 8'h97);

        // Load 21, borrow from tens.
        cycle(1'b1, 1'b0, 8'h21);
        repeat (2) cycle(1'b0, 1'b1, 8'h00);
        check("plan 19", int'(q_w), 8'h19);

        // Countdown to zero then hold / wrap.
        cycle(1'b1, 1'b0, 8'h02);
        repeat (4) cycle(1'b0, 1'b1, 8'h00);
        check("plan stop held", int'(q_s), 8'h00);

        // Invalid digit load.
        cycle(1'b1, 1'b0, 8'hA3);
        check("plan A3 -> 93", int'(q_w), 8'h93);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'hFF);
        cycle(1'b1, 1'b0, 8'h5C);

        // Load beats enable.
        cycle(1'b1, 1'b0, 8'h37);
        cycle(1'b1, 1'b1, 8'h50);
        check("plan prio 50", int'(q_w), 8'h50);
        cycle(1'b0, 1'b1, 8'h00);
        check("plan 49", int'(q_w), 8'h49);

        // Async reset at 45, then resume.
        repeat (4) cycle(1'b0, 1'b1, 8'h00);
        check("plan 45", int'(q_w), 8'h45);
        async_reset();
        repeat (2) cycle(1'b0, 1'b1, 8'h00);

        // Randomised traffic including invalid loads and occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 2) begin
                async_reset();
            end else begin
                cycle(($urandom_range(99) < 8) ? 1'b1 : 1'b0,
                      ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                      ($urandom_range(3) == 0) ? W'($urandom_range(3)) : W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
